// File: rtl/fsk_rx_pkg.sv
// Shared state encoding, default parameters and width helper for the FSK receive sequencer.
package fsk_rx_pkg;

   localparam int CLKS_PER_BIT_DEF = 64;
   localparam int EDGE_THRESH_DEF  = 4;
   localparam int CODE_W_DEF       = 14;
   localparam int IDLE_GAP_DEF     = 16;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] RECV  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   // One spare bit so a fully toggling window can never wrap the edge count.
   function automatic int edge_cnt_width(input int clks_per_bit);
      return $clog2(clks_per_bit) + 1;
   endfunction

endpackage

// File: rtl/fsk_bit_slicer.sv
// Times one bit window, counts rising edges in it and slices the count to a bit.
// With FSK_RX_CARRIER_CHECK_EN defined it also flags a window that saw no edges.
module fsk_bit_slicer
   import fsk_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int EDGE_THRESH  = EDGE_THRESH_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic run,
   input  logic edge_pulse,
   output logic win_end,
   output logic bit_val
`ifdef FSK_RX_CARRIER_CHECK_EN
   ,
   output logic win_empty
`endif
);

   localparam int WW = $clog2(CLKS_PER_BIT);
   localparam int EW = edge_cnt_width(CLKS_PER_BIT);
   localparam logic [WW-1:0] WIN_LAST = WW'(CLKS_PER_BIT - 1);
   localparam logic [EW-1:0] EDGE_MAX = '1;
   localparam logic [EW-1:0] THRESH   = EW'(EDGE_THRESH);

   logic [WW-1:0] win_cnt;
   logic [EW-1:0] edge_cnt;

   assign win_end = run && (win_cnt == WIN_LAST);
   assign bit_val = (edge_cnt >= THRESH);
`ifdef FSK_RX_CARRIER_CHECK_EN
   assign win_empty = (edge_cnt == '0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_cnt  <= '0;
         edge_cnt <= '0;
      end else if (start) begin
         // The edge that triggered the frame is the first edge of window 0.
         win_cnt  <= '0;
         edge_cnt <= EW'(1);
      end else if (run) begin
         if (win_cnt == WIN_LAST) begin
            // An edge on the last clock belongs to the next window.
            win_cnt  <= '0;
            edge_cnt <= edge_pulse ? EW'(1) : '0;
         end else begin
            win_cnt <= win_cnt + 1'b1;
            if (edge_pulse && (edge_cnt != EDGE_MAX))
               edge_cnt <= edge_cnt + 1'b1;
         end
      end else begin
         win_cnt  <= '0;
         edge_cnt <= '0;
      end
   end

endmodule

// File: rtl/fsk_rx_frame_ctrl.sv
// FSK receive sequencer: syncs the line, frames sliced bits into CODE_W-bit codewords and
// hands them to the decoder over valid/ready. FSK_RX_CARRIER_CHECK_EN adds carrier_err.
module fsk_rx_frame_ctrl
   import fsk_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int EDGE_THRESH  = EDGE_THRESH_DEF,
   parameter int CODE_W       = CODE_W_DEF,
   parameter int IDLE_GAP     = IDLE_GAP_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      fsk_in,
   output logic [CODE_W-1:0]         code_data,
   output logic                      code_valid,
   input  logic                      code_ready,
   output logic                      busy,
   output logic [$clog2(CODE_W)-1:0] bit_index,
   output logic                      overrun,
   input  logic                      overrun_clr
`ifdef FSK_RX_CARRIER_CHECK_EN
   ,
   output logic                      carrier_err
`endif
);

   localparam int IW = $clog2(CODE_W);
   localparam int QW = $clog2(IDLE_GAP + 1);
   localparam logic [IW-1:0] BIT_LAST = IW'(CODE_W - 1);
   localparam logic [QW-1:0] GAP      = QW'(IDLE_GAP);

   logic [1:0]        state;
   logic [2:0]        sync;
   logic              edge_pulse;
   logic [QW-1:0]     quiet_cnt;
   logic [CODE_W-1:0] shift_data;
   logic [IW-1:0]     pos;
   logic              win_end;
   logic              bit_val;
   logic              carrier_abort;

   // sync[1:0] is the two-flop synchronizer, sync[2] the previous synced value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sync <= '0;
      else
         sync <= {sync[1:0], fsk_in};
   end

   assign edge_pulse = sync[1] & ~sync[2];
   assign busy       = (state == START) || (state == RECV);
   assign pos        = BIT_LAST - bit_index;

`ifdef FSK_RX_CARRIER_CHECK_EN
   logic win_empty;

   fsk_bit_slicer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .EDGE_THRESH  (EDGE_THRESH)
   ) u_slicer (
      .clk        (clk),
      .reset      (reset),
      .start      (state == START),
      .run        (state == RECV),
      .edge_pulse (edge_pulse),
      .win_end    (win_end),
      .bit_val    (bit_val),
      .win_empty  (win_empty)
   );

   assign carrier_abort = win_end && win_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         carrier_err <= 1'b0;
      else
         carrier_err <= carrier_abort && enable;
   end
`else
   fsk_bit_slicer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .EDGE_THRESH  (EDGE_THRESH)
   ) u_slicer (
      .clk        (clk),
      .reset      (reset),
      .start      (state == START),
      .run        (state == RECV),
      .edge_pulse (edge_pulse),
      .win_end    (win_end),
      .bit_val    (bit_val)
   );

   assign carrier_abort = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         quiet_cnt  <= '0;
         bit_index  <= '0;
         shift_data <= '0;
         code_data  <= '0;
         code_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (code_valid && code_ready)
            code_valid <= 1'b0;
         if (overrun_clr)
            overrun <= 1'b0;

         case (state)
            IDLE: begin
               bit_index <= '0;
               if (edge_pulse)
                  quiet_cnt <= '0;
               else if (quiet_cnt < GAP)
                  quiet_cnt <= quiet_cnt + 1'b1;
               if (edge_pulse && enable && (quiet_cnt >= GAP))
                  state <= START;
            end
            START: begin
               shift_data <= '0;
               bit_index  <= '0;
               state      <= enable ? RECV : IDLE;
            end
            RECV: begin
               if (!enable || carrier_abort) begin
                  state     <= IDLE;
                  bit_index <= '0;
               end else if (win_end) begin
                  shift_data[pos] <= bit_val;
                  if (bit_index == BIT_LAST)
                     state <= DONE;
                  else
                     bit_index <= bit_index + 1'b1;
               end
            end
            DONE: begin
               // A same-cycle transfer consumes the old word, so only an unconsumed one overruns.
               code_data  <= shift_data;
               code_valid <= 1'b1;
               if (code_valid && !code_ready)
                  overrun <= 1'b1;
               quiet_cnt <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
